select_decode_unit: RTL and testbench

//   Register-select and decode stage of the datapath, working in the opposite direction to the bus-source encoder.
//   - Latches the instruction register (IR) and picks one 4-bit register field (ra/rb/rc) under control of the sequencer.
//   - Decodes that field to 16-bit one-hot R*in/R*out register enables, one clock after the request.
//   - Also provides the sign-extended C constant and the opcode to the control unit.

---
 rtl/select_decode_unit_pkg.sv | 23 ++
 rtl/select_decode_unit_onehot_decoder.sv | 16 +
 rtl/select_decode_unit.sv | 86 ++++++++
 tb/tb_select_decode_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/select_decode_unit_pkg.sv
// Shared constants and types for the register-select/decode stage.
// IR field positions and register file sizing.
package select_decode_unit_pkg;

    localparam int DATA_W  = 32;
    localparam int NREGS   = 16;
    localparam int IDX_W   = $clog2(NREGS);
    localparam int C_W     = 19;
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;
    localparam int RA_MSB  = 26;
    localparam int RB_MSB  = 22;
    localparam int RC_MSB  = 18;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_RA,
        SEL_RB,
        SEL_RC
    } sel_e;

endpackage

// File: rtl/select_decode_unit_onehot_decoder.sv
// Combinational index-to-one-hot decoder with enable.
// Output is all zeros when en is low.
module onehot_decoder #(
    parameter int IDX_W = 4
) (
    input  logic               en,
    input  logic [IDX_W-1:0]   idx,
    output logic [2**IDX_W-1:0] out
);

    always_comb begin
        out = '0;
        if (en) out[idx] = 1'b1;
    end

endmodule

// File: rtl/select_decode_unit.sv
// Register-select and decode stage: latches IR, picks ra/rb/rc
// and drives registered one-hot R*in/R*out enables.
module select_decode_unit
    import select_decode_unit_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [DATA_W-1:0] ir_in,
    input  logic              ir_load,
    input  logic              gra,
    input  logic              grb,
    input  logic              grc,
    input  logic              r_in_en,
    input  logic              r_out_en,
    input  logic              ba_out,
    output logic [NREGS-1:0]  r_in,
    output logic [NREGS-1:0]  r_out,
    output logic              bus_zero,
    output logic [DATA_W-1:0] c_sign_ext,
    output logic [OPC_W-1:0]  opcode,
    output logic              sel_err
);

    logic [DATA_W-1:0] ir;
    logic [IDX_W-1:0]  idx;
    logic              any_g;
    logic              multi_g;
    sel_e              sel;
    logic [NREGS-1:0]  in_oh;
    logic [NREGS-1:0]  out_oh;

    assign opcode     = ir[OPC_MSB:OPC_LSB];
    assign c_sign_ext = {{(DATA_W-C_W){ir[C_W-1]}}, ir[C_W-1:0]};

    assign any_g   = gra | grb | grc;
    assign multi_g = (gra & grb) | (gra & grc) | (grb & grc);

    // gra wins over grb, grb over grc
    always_comb begin
        sel = SEL_NONE;
        if (gra)      sel = SEL_RA;
        else if (grb) sel = SEL_RB;
        else if (grc) sel = SEL_RC;
    end

    always_comb begin
        idx = '0;
        case (sel)
            SEL_RA:   idx = ir[RA_MSB -: IDX_W];
            SEL_RB:   idx = ir[RB_MSB -: IDX_W];
            SEL_RC:   idx = ir[RC_MSB -: IDX_W];
            default:  idx = '0;
        endcase
    end

    onehot_decoder #(.IDX_W(IDX_W)) u_in_dec (
        .en  (r_in_en & any_g),
        .idx (idx),
        .out (in_oh)
    );

    onehot_decoder #(.IDX_W(IDX_W)) u_out_dec (
        .en  ((r_out_en | ba_out) & any_g),
        .idx (idx),
        .out (out_oh)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ir       <= '0;
            r_in     <= '0;
            r_out    <= '0;
            bus_zero <= 1'b0;
            sel_err  <= 1'b0;
        end else begin
            if (ir_load) ir <= ir_in;
            r_in     <= in_oh;
            r_out    <= out_oh;
            bus_zero <= ba_out & any_g & (idx == '0);
            // a multi-select in the load cycle keeps the flag set
            if (multi_g)      sel_err <= 1'b1;
            else if (ir_load) sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_select_decode_unit.sv
// Scoreboard bench for select_decode_unit: a reference model
// pushes expected outputs per cycle, popped after each edge.
module tb_select_decode_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic [31:0] ir_in = '0;
    logic        ir_load = 1'b0;
    logic        gra = 1'b0;
    logic        grb = 1'b0;
    logic        grc = 1'b0;
    logic        r_in_en = 1'b0;
    logic        r_out_en = 1'b0;
    logic        ba_out = 1'b0;
    logic [15:0] r_in;
    logic [15:0] r_out;
    logic        bus_zero;
    logic [31:0] c_sign_ext;
    logic [4:0]  opcode;
    logic        sel_err;

    typedef struct {
        logic [15:0] r_in;
        logic [15:0] r_out;
        logic        bz;
        logic        err;
        logic [4:0]  opc;
        logic [31:0] c;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_ir = '0;
    logic        m_err = 1'b0;
    int          errors = 0;
    int          checks = 0;

    select_decode_unit dut (
        .clk        (clk),
        .clr        (clr),
        .ir_in      (ir_in),
        .ir_load    (ir_load),
        .gra        (gra),
        .grb        (grb),
        .grc        (grc),
        .r_in_en    (r_in_en),
        .r_out_en   (r_out_en),
        .ba_out     (ba_out),
        .r_in       (r_in),
        .r_out      (r_out),
        .bus_zero   (bus_zero),
        .c_sign_ext (c_sign_ext),
        .opcode     (opcode),
        .sel_err    (sel_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input logic        ld,
                        input logic [31:0] v,
                        input logic        a,
                        input logic        b,
                        input logic        c,
                        input logic        ie,
                        input logic        oe,
                        input logic        ba);
        exp_t        e;
        exp_t        p;
        logic [3:0]  i;
        logic [15:0] oh;
        logic        any;
        ir_load = ld; ir_in = v;
        gra = a; grb = b; grc = c;
        r_in_en = ie; r_out_en = oe; ba_out = ba;
        any = a | b | c;
        if (a)      i = m_ir[26:23];
        else if (b) i = m_ir[22:19];
        else        i = m_ir[18:15];
        oh = any ? (16'h1 << i) : 16'h0;
        e.r_in  = ie ? oh : 16'h0;
        e.r_out = (oe | ba) ? oh : 16'h0;
        e.bz    = ba & any & (i == 4'd0);
        if ((a & b) | (a & c) | (b & c)) m_err = 1'b1;
        else if (ld)                     m_err = 1'b0;
        if (ld) m_ir = v;
        e.err = m_err;
        e.opc = m_ir[31:27];
        e.c   = {{13{m_ir[18]}}, m_ir[18:0]};
        sb.push_back(e);
        @(posedge clk);
        #1;
        p = sb.pop_front();
        chk("r_in",     32'(r_in),       32'(p.r_in));
        chk("r_out",    32'(r_out),      32'(p.r_out));
        chk("bus_zero", 32'(bus_zero),   32'(p.bz));
        chk("sel_err",  32'(sel_err),    32'(p.err));
        chk("opcode",   32'(opcode),     32'(p.opc));
        chk("c_sext",   c_sign_ext,      p.c);
        ir_load = 1'b0;
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        r_in_en = 1'b0; r_out_en = 1'b0; ba_out = 1'b0;
    endtask

    initial begin
        #1;
        chk("rst_r_in",   32'(r_in),     32'h0);
        chk("rst_r_out",  32'(r_out),    32'h0);
        chk("rst_bz",     32'(bus_zero), 32'h0);
        chk("rst_err",    32'(sel_err),  32'h0);
        chk("rst_opcode", 32'(opcode),   32'h0);
        chk("rst_c",      c_sign_ext,    32'h0);
        #2 clr = 1'b1;

        // load and constant outputs
        step(1, 32'h192C8000, 0,0,0, 0,0,0);
        chk("t1_opcode", 32'(opcode), 32'd3);
        chk("t1_c", c_sign_ext, 32'hFFFC8000);

        // field selection
        step(0, 0, 1,0,0, 1,0,0);
        chk("t2_ra_in", 32'(r_in), 32'h0004);
        chk("t2_ra_out", 32'(r_out), 32'h0);
        step(0, 0, 0,0,0, 0,0,0);
        chk("t2_pulse", 32'(r_in), 32'h0);
        step(0, 0, 0,1,0, 0,1,0);
        chk("t2_rb_out", 32'(r_out), 32'h0020);
        step(0, 0, 0,0,1, 1,1,0);
        chk("t2_rc_in", 32'(r_in), 32'h0200);
        chk("t2_rc_out", 32'(r_out), 32'h0200);
        step(0, 0, 0,0,0, 1,1,1);
        chk("t2_noneg", 32'(r_out), 32'h0);

        // base-address out with R0
        step(1, 32'h08000000, 0,0,0, 0,0,0);
        step(0, 0, 1,0,0, 0,0,1);
        chk("t3_ba_out", 32'(r_out), 32'h0001);
        chk("t3_bz", 32'(bus_zero), 32'h1);
        step(0, 0, 1,0,0, 0,1,0);
        chk("t3_nobz", 32'(bus_zero), 32'h0);

        // multi-select error
        step(1, 32'h192C8000, 0,0,0, 0,0,0);
        step(0, 0, 1,1,0, 1,0,0);
        chk("t4_err", 32'(sel_err), 32'h1);
        chk("t4_prio", 32'(r_in), 32'h0004);
        step(0, 0, 0,0,0, 0,0,0);
        chk("t4_sticky", 32'(sel_err), 32'h1);
        step(0, 0, 0,1,1, 0,1,0);
        chk("t4_prio_bc", 32'(r_out), 32'h0020);
        step(1, 32'h192C8000, 0,0,0, 0,0,0);
        chk("t4_clear", 32'(sel_err), 32'h0);
        step(1, 32'h192C8000, 1,0,1, 0,0,0);
        chk("t4_setwins", 32'(sel_err), 32'h1);
        step(1, 32'h192C8000, 0,0,0, 0,0,0);

        // load in same cycle as select uses old IR
        step(1, 32'h00000000, 1,0,0, 1,0,0);
        chk("t5_old", 32'(r_in), 32'h0004);
        step(0, 0, 1,0,0, 1,0,0);
        chk("t5_new", 32'(r_in), 32'h0001);

        // random traffic
        for (int k = 0; k < 60; k++) begin
            step(($urandom_range(0, 3) == 0), $urandom,
                 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // asynchronous reset mid-request
        step(1, 32'h192C8000, 0,0,0, 0,0,0);
        step(0, 0, 1,1,0, 1,1,0);
        gra = 1'b1; r_in_en = 1'b1; r_out_en = 1'b1;
        #2 clr = 1'b0;
        #1;
        chk("t6_r_out", 32'(r_out), 32'h0);
        chk("t6_r_in", 32'(r_in), 32'h0);
        chk("t6_err", 32'(sel_err), 32'h0);
        chk("t6_opcode", 32'(opcode), 32'h0);
        chk("t6_c", c_sign_ext, 32'h0);
        m_ir = '0;
        m_err = 1'b0;
        sb.delete();
        #1 clr = 1'b1;
        step(0, 0, 1,0,0, 0,1,0);
        chk("t6_after", 32'(r_out), 32'h0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
